// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract with carry, overflow and zero flags; SERIAL_ADDSUB_2BIT_EN doubles the bits per cycle.
// Latency: done is high in the cycle after the WIDTH-th edge following start (WIDTH/2 with SERIAL_ADDSUB_2BIT_EN).
// Backpressure: none; start while busy is dropped, and start during done begins the next operation at once.
module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

`ifdef SERIAL_ADDSUB_2BIT_EN
  localparam int SH = 2;
`else
  localparam int SH = 1;
`endif
  localparam int STEPS = WIDTH / SH;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("serial_addsub: WIDTH must be at least 2");
  end
`ifdef SERIAL_ADDSUB_2BIT_EN
  if (WIDTH % 2 != 0) begin : g_even_chk
    $error("serial_addsub: WIDTH must be even when two bits are processed per cycle");
  end
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             load, step, last;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry, c_out, ovf_cin;
  logic [CW-1:0]    cnt;

  assign last = (cnt == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ADDSUB_2BIT_EN
  logic s0, s1, c_mid;

  // Two chained slices; the lower slice's carry is the carry into the MSB on the final step.
  always_comb begin
    s0      = a_sr[0] ^ b_sr[0] ^ carry;
    c_mid   = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    s1      = a_sr[1] ^ b_sr[1] ^ c_mid;
    c_out   = (a_sr[1] & b_sr[1]) | ((a_sr[1] ^ b_sr[1]) & c_mid);
    res_nxt = (res_sr >> 2) | (WIDTH'({s1, s0}) << (WIDTH - 2));
    ovf_cin = c_mid;
  end
`else
  logic s0, cin_msb;

  always_comb begin
    s0      = a_sr[0] ^ b_sr[0] ^ carry;
    c_out   = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    res_nxt = (res_sr >> 1) | (WIDTH'(s0) << (WIDTH - 1));
    ovf_cin = cin_msb;
  end

  // Carry produced by bit WIDTH-2 feeds the MSB slice on the next step.
  always_ff @(posedge clk) begin
    if (reset)                                 cin_msb <= 1'b0;
    else if (step && cnt == CW'(WIDTH - 2))    cin_msb <= c_out;
  end
`endif

  // The working shift register is separate from result so outputs hold during RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> SH;
      b_sr   <= b_sr >> SH;
      res_sr <= res_nxt;
      carry  <= c_out;
      cnt    <= cnt + CW'(1);
      if (last) begin
        result   <= res_nxt;
        carryout <= c_out;
        overflow <= ovf_cin ^ c_out;
        zero     <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: per-cycle comparison against an arithmetic reference plus directed literal checks.
module tb_serial_addsub;
  localparam int W = 32;
`ifdef SERIAL_ADDSUB_2BIT_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carryout, overflow, zero;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  int tests = 0;
  int fails = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic from plain integer operations
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v,
                                 output logic z);
    logic [W:0] full;
    if (s) full = {1'b0, x} - {1'b0, y};
    else   full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    c = s ? (x >= y) : full[W];
    if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    z = (r == '0);
  endfunction

  logic         m_busy = 0, m_done = 0, m_c = 0, m_v = 0, m_z = 0;
  logic [W-1:0] m_res = '0;
  logic         p_c, p_v, p_z;
  logic [W-1:0] p_res;
  int           m_left = 0;
  bit           chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_res = '0; m_c = 0; m_v = 0; m_z = 0; m_left = 0;
    end else if (!m_busy && start) begin
      m_busy = 1; m_done = 0; m_left = LAT;
      ref_op(a, b, sub, p_res, p_c, p_v, p_z);
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
        m_res = p_res; m_c = p_c; m_v = p_v; m_z = p_z;
      end
    end else begin
      m_done = 0;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("result", result, m_res);
      check("carryout", carryout, m_c);
      check("overflow", overflow, m_v);
      check("zero", zero, m_z);
      if (done) n_done++;
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input logic [W-1:0] er, input logic ec,
                           input logic ev, input logic ez);
    int n;
    issue(x, y, s);
    wait_done(n);
    check({nm, " latency"}, n, LAT + 1);
    check({nm, " result"}, result, er);
    check({nm, " carryout"}, carryout, ec);
    check({nm, " overflow"}, overflow, ev);
    check({nm, " zero"}, zero, ez);
  endtask

  initial begin
    int n;
    int d0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset flags", {carryout, overflow, zero}, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;

    run_check("add49_67", 32'd49, 32'd67, 1'b0, 32'd116, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    run_check("sub49_67", 32'd49, 32'd67, 1'b1, 32'hFFFF_FFEE, 1'b0, 1'b0, 1'b0);
    run_check("sub67_49_b2b", 32'd67, 32'd49, 1'b1, 32'd18, 1'b1, 1'b0, 1'b0);
    run_check("add_pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_check("sub_neg_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_check("add_wrap_zero", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    run_check("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // start while busy must be ignored
    issue(32'd1000, 32'd234, 1'b0);
    repeat (5) @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = n_done;
    wait_done(n);
    check("ignore latency", n, LAT - 4);
    check("ignore result", result, 32'd1234);
    repeat (LAT + 5) @(negedge clk);
    check("ignore single done", n_done - d0, 1);

    // reset in the middle of RUN aborts with no done pulse
    @(posedge clk);
    #1;
    issue(32'd5, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    d0 = n_done;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort result", result, 0);
    check("abort flags", {done, carryout, overflow, zero}, 4'b0000);
    repeat (40) @(negedge clk);
    check("abort no done", n_done - d0, 0);
    run_check("after_abort", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
